// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider and its HI/LO writeback.
package div_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_CYCLES = 32;

   // Packed result is {remainder, quotient}: quotient lands in LO, remainder in HI.
   localparam int QUO_LSB = 0;

   function automatic int rem_lsb(input int width);
      return width;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic             unused_bit;

   // Two guard bits: the shifted remainder can reach 2^(WIDTH+1)-1.
   assign diff       = {1'b0, rem_i, quo_i[WIDTH-1]} - {2'b00, dvsr_i};
   assign borrow     = diff[WIDTH+1];
   assign shifted    = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
   assign unused_bit = diff[WIDTH];

   assign rem_o = borrow ? shifted : diff[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the execute stage; stalls the pipe
// while iterating and pulses div_validE with {remainder, quotient}.
module div_unit #(
   parameter int WIDTH      = 32,
   parameter int DIV_CYCLES = div_unit_pkg::DIV_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startE,
   input  logic               signedE,
   input  logic               flushE,
   input  logic [WIDTH-1:0]   src_aE,
   input  logic [WIDTH-1:0]   src_bE,
   output logic               div_stallE,
   output logic               div_validE,
   output logic [2*WIDTH-1:0] div_resultE
);
   import div_unit_pkg::*;

   localparam int REM_LSB = rem_lsb(WIDTH);
   localparam int CW      = $clog2(DIV_CYCLES) + 1;

   div_state_t       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
   logic             signed_q, a_sgn_q, b_sgn_q;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   rem_nx, quo_nx;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic [2*WIDTH-1:0] res_nx;
   logic               accept;

   assign a_mag  = (signedE && src_aE[WIDTH-1]) ? -src_aE : src_aE;
   assign b_mag  = (signedE && src_bE[WIDTH-1]) ? -src_bE : src_bE;
   assign accept = (state_q == IDLE) && startE && !flushE;

   // Gated by rst so the stall drops immediately under reset even with startE high.
   assign div_stallE = rst && (accept || state_q == BUSY);
   assign div_validE = (state_q == DONE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (rem_nx),
      .quo_o  (quo_nx)
   );

   // Sign fix-up on the final step; a zero divisor already yields rem = |a|,
   // so only the quotient needs forcing to all ones.
   always_comb begin
      q_fix = (signed_q && (a_sgn_q ^ b_sgn_q)) ? -quo_nx : quo_nx;
      r_fix = (signed_q && a_sgn_q) ? -rem_nx : rem_nx;
      if (dvsr_q == '0) q_fix = '1;
      res_nx = '0;
      res_nx[QUO_LSB +: WIDTH] = q_fix;
      res_nx[REM_LSB +: WIDTH] = r_fix;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         signed_q    <= 1'b0;
         a_sgn_q     <= 1'b0;
         b_sgn_q     <= 1'b0;
         div_resultE <= '0;
      end else if (flushE) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (startE) begin
               state_q  <= BUSY;
               cnt_q    <= '0;
               rem_q    <= '0;
               quo_q    <= a_mag;
               dvsr_q   <= b_mag;
               signed_q <= signedE;
               a_sgn_q  <= src_aE[WIDTH-1];
               b_sgn_q  <= src_bE[WIDTH-1];
            end
            BUSY: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                  state_q     <= DONE;
                  div_resultE <= res_nx;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a driver pushes expected results, a monitor pops on div_validE.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        startE, signedE, flushE;
   logic [31:0] src_aE, src_bE;
   logic        div_stallE, div_validE;
   logic [63:0] div_resultE;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   div_unit #(.WIDTH(32), .DIV_CYCLES(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .startE      (startE),
      .signedE     (signedE),
      .flushE      (flushE),
      .src_aE      (src_aE),
      .src_bE      (src_bE),
      .div_stallE  (div_stallE),
      .div_validE  (div_validE),
      .div_resultE (div_resultE)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && div_validE === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: result %h with nothing pending (cycle %0d)", div_resultE, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", div_resultE, e.res);
            chk("valid_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Call at the start of a cycle (after posedge, or mid-cycle); returns at start of cycle 34.
   task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
      exp_t e;
      startE = 1'b1; signedE = s; src_aE = a; src_bE = b;
      e.res = exp; e.cyc = cyc + 33;
      exp_q.push_back(e);
      @(negedge clk) chk1("stall_c0", div_stallE, 1'b1);
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            startE = 1'b0; src_aE = ~a; src_bE = b + 32'd3; signedE = ~s;
         end
         if (i == 5) begin
            startE = 1'b1; src_aE = 32'd1234; src_bE = 32'd5;
         end
         if (i == 6) startE = 1'b0;
         @(negedge clk) chk1("stall_busy", div_stallE, 1'b1);
      end
      @(posedge clk); #1;
      startE = 1'b1;
      @(negedge clk) chk1("stall_done", div_stallE, 1'b0);
      @(posedge clk); #1;
      startE = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] last;
      rst = 1'b0; startE = 1'b1; signedE = 1'b0; flushE = 1'b0;
      src_aE = 32'd0; src_bE = 32'd0;
      #1;
      chk1("rst_stall", div_stallE, 1'b0);
      chk1("rst_valid", div_validE, 1'b0);
      chk("rst_result", div_resultE, 64'h0);
      startE = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;

      run_div(1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E});
      run_div(1'b1, 32'hFFFFFFF9,   32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000});
      run_div(1'b0, 32'd5,          32'd0,        {32'h00000005, 32'hFFFFFFFF});
      run_div(1'b1, 32'hFFFFFFF9,   32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF});
      run_div(1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF});
      run_div(1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
      run_div(1'b0, 32'hFFFFFFF9,   32'd2,        {32'h00000001, 32'h7FFFFFFC});
      last = {32'hFFFFFFFE, 32'h0000000E};
      run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, last);

      // Flush in cycle 10 of a divide.
      startE = 1'b1; signedE = 1'b0; src_aE = 32'd1000; src_bE = 32'd3;
      @(negedge clk) chk1("fl_stall_c0", div_stallE, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 1) startE = 1'b0;
         if (i == 10) flushE = 1'b1;
         @(negedge clk) chk1("fl_stall_busy", div_stallE, 1'b1);
      end
      @(posedge clk); #1;
      flushE = 1'b0;
      @(negedge clk);
      chk1("fl_stall_idle", div_stallE, 1'b0);
      chk1("fl_valid", div_validE, 1'b0);
      chk("fl_result_held", div_resultE, last);
      repeat (30) @(negedge clk);
      chk("fl_result_after", div_resultE, last);

      // Start and flush together in IDLE: nothing accepted.
      @(posedge clk); #1;
      startE = 1'b1; flushE = 1'b1;
      @(negedge clk) chk1("sf_stall", div_stallE, 1'b0);
      @(posedge clk); #1;
      startE = 1'b0; flushE = 1'b0;
      @(negedge clk) chk1("sf_stall_next", div_stallE, 1'b0);
      repeat (40) @(negedge clk);
      chk("sf_no_result", div_resultE, last);
      @(posedge clk); #1;

      run_div(1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003});

      // Asynchronous reset in the middle of a BUSY cycle.
      startE = 1'b1; signedE = 1'b0; src_aE = 32'd200; src_bE = 32'd9;
      @(posedge clk); #1;
      startE = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk1("arst_stall", div_stallE, 1'b0);
      chk1("arst_valid", div_validE, 1'b0);
      chk("arst_result", div_resultE, 64'h0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      run_div(1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E});

      repeat (5) @(posedge clk);
      chk("pending_left", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter DIV_CYCLES, default 32, iteration count; SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 startE  input  1  divide request from decode/execute control.
REQ-006 signedE  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with startE.
REQ-007 flushE  input  1  pipeline flush or exception; cancels any operation.
REQ-008 src_aE  input  WIDTH  dividend.
REQ-009 src_bE  input  WIDTH  divisor.
REQ-010 div_stallE  output  1  freezes the execute stage while the divide is in progress.
REQ-011 div_validE  output  1  result valid, high for exactly one cycle.
REQ-012 div_resultE  output  2*WIDTH  {remainder, quotient}, written to HI/LO.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE with startE=1 and flushE=0 SHALL accept: capture operand magnitudes, signedE and result signs, clear the counter, and go to BUSY.
REQ-015 BUSY SHALL run one restoring shift-subtract step per cycle.
- After DIV_CYCLES steps the FSM SHALL go to DONE.
- The transition into DONE SHALL write the sign-corrected result to the div_resultE register.
REQ-016 DONE SHALL return to IDLE on the next edge.
- A startE seen while in DONE or BUSY SHALL be ignored.
REQ-017 div_stallE SHALL be combinational: high when (IDLE and startE and not flushE) or BUSY; low in DONE.
REQ-018 Latency: with the accept in cycle 0, div_stallE is high in cycles 0..32, and div_validE is high and div_resultE valid in cycle 33.
REQ-019 div_validE SHALL be high exactly while in DONE.
REQ-020 div_resultE SHALL hold its value until the next DONE.
REQ-021 Operands SHALL be used only as captured at accept; later changes on src_aE/src_bE have no effect.
REQ-022 Signed results:
- the quotient is negative iff the operand signs differ;
- the remainder takes the sign of the dividend.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no exception).
REQ-024 A divisor of 0, signed or unsigned, SHALL give quotient 0xFFFFFFFF and remainder = the dividend; no exception is raised.
REQ-025 flushE=1 in any state SHALL force IDLE on the next edge, with no div_validE pulse and div_resultE unchanged.
- flushE and startE together in IDLE: flush wins and nothing is accepted.

Reset
REQ-026 rst=0 SHALL immediately, regardless of clk or state, set: state = IDLE, counter = 0, div_resultE = 0, div_validE = 0, div_stallE = 0.
REQ-027 Deasserting reset SHALL leave the block in IDLE, ready to accept a start on the first following edge.

Structure
REQ-028 A shared package SHALL hold:
- the div_state_t enum (IDLE, BUSY, DONE);
- the DIV_CYCLES constant;
- the {remainder, quotient} field-position constants used by the HI/LO writeback.
REQ-029 One combinational sub-module, div_step, SHALL implement a single shift-subtract iteration: inputs are the partial remainder, the quotient and the divisor; outputs are the next remainder and quotient.
REQ-030 Sign correction and the divide-by-zero override SHALL live in div_unit, not in div_step.

Verification
REQ-031 Unsigned 100 / 7: accept at cycle 0 -> div_stallE high in cycles 0..32; cycle 33 shows div_validE=1 and result {0x00000002, 0x0000000E}.
REQ-032 Signed 0xFFFFFFF9 / 0x00000002 -> result {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> result {0x00000000, 0x80000000}, with no exception.
REQ-034 Unsigned 5 / 0 -> result {0x00000005, 0xFFFFFFFF}, div_validE in cycle 33.
REQ-035 flushE pulsed in cycle 10 of a divide -> IDLE in cycle 11 with div_stallE=0 and no div_validE. A new 9 / 3 started afterwards -> {0, 3} 33 cycles after its accept.
REQ-036 rst driven low in the middle of a BUSY cycle -> all outputs 0 before the next clock edge. After release, startE is accepted on the first edge.
